// File: rtl/multiplier.sv
// Sequential signed WIDTH x WIDTH multiplier: shift-add over operand magnitudes,
// then one cycle to apply the sign. start/ready/done handshake toward ALU control.
//
// state | meaning
// IDLE  | waiting for start; ready=1, last product held on the outputs
// RUN   | one shift-add step per clock, WIDTH steps
// SIGN  | negate accumulator if needed, publish product, pulse done
module multiplier #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CTR_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SIGN = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;
  logic               neg;
  logic [CW-1:0]      ctr;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc_neg;

  // Magnitudes as unsigned; the most negative value maps onto 2^(WIDTH-1).
  always_comb begin
    mag_a   = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
    mag_b   = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    acc_neg = ~acc + (2*WIDTH)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = RUN;
      end
      RUN: begin
        if (ctr == CTR_LAST) state_nxt = SIGN;
      end
      SIGN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand      <= '0;
      acc        <= '0;
      neg        <= 1'b0;
      ctr        <= '0;
      done       <= 1'b0;
      product_hi <= '0;
      product_lo <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mcand <= mag_a;
            acc   <= {{WIDTH{1'b0}}, mag_b};
            neg   <= a[WIDTH-1] ^ b[WIDTH-1];
            ctr   <= '0;
          end
        end
        RUN: begin
          acc <= {sum, acc[WIDTH-1:1]};
          ctr <= ctr + CW'(1);
        end
        SIGN: begin
          {product_hi, product_lo} <= neg ? acc_neg : acc;
          done                     <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
